// File: rtl/fpv_pkg.sv
// Shared constants, state encoding and colour helpers for the first-person-view renderer.
package fpv_pkg;

  localparam int unsigned SCREEN_W = 32'd160;
  localparam int unsigned SCREEN_H = 32'd120;

  localparam logic [7:0] LAST_COL    = 8'(SCREEN_W - 32'd1);
  localparam logic [6:0] LAST_ROW    = 7'(SCREEN_H - 32'd1);
  localparam logic [6:0] MAX_H       = 7'(SCREEN_H);
  localparam logic [6:0] SHADE_LIMIT = 7'd30;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_PAINT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    LATCH = ST_LATCH,
    PAINT = ST_PAINT,
    DONE  = ST_DONE
  } state_t;

  localparam logic [17:0] CEILING    = 18'h0003F;
  localparam logic [17:0] FLOOR      = 18'h0F3CF;
  localparam logic [17:0] WALL_T1    = 18'h3F000;
  localparam logic [17:0] WALL_T2    = 18'h00FC0;
  localparam logic [17:0] WALL_T3    = 18'h0003F;
  localparam logic [17:0] WALL_OTHER = 18'h3FFFF;

  // Halves each 6-bit channel of a 6:6:6 colour independently.
  function automatic logic [17:0] halve_channels(input logic [17:0] c);
    return {1'b0, c[17:13], 1'b0, c[11:7], 1'b0, c[5:1]};
  endfunction

  function automatic logic [17:0] pixel_colour(input logic [6:0] y, input logic [6:0] top,
                                               input logic [6:0] bottom, input logic [17:0] wall);
    logic [17:0] c;
    if (y < top) begin
      c = CEILING;
    end else if (y < bottom) begin
      c = wall;
    end else begin
      c = FLOOR;
    end
    return c;
  endfunction

endpackage

// File: rtl/draw_fpv_if.sv
// Start/done handshake, wall-table read port and shared VGA write port of the FPV pass.
interface draw_fpv_if;
  logic        start;
  logic        done;
  logic [7:0]  col_addr;
  logic [6:0]  col_height;
  logic [2:0]  col_type;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [17:0] vga_colour;
  logic        vga_write;
  logic        vga_ready;

  modport master (
    output start, col_height, col_type, vga_ready,
    input  done, col_addr, vga_x, vga_y, vga_colour, vga_write
  );

  modport slave (
    input  start, col_height, col_type, vga_ready,
    output done, col_addr, vga_x, vga_y, vga_colour, vga_write
  );
endinterface

// File: rtl/fpv_wall_colour.sv
// Combinational wall colour lookup: cell type to base colour, halved for distant (short) walls.
module fpv_wall_colour
  import fpv_pkg::*;
(
  input  logic [2:0]  col_type,
  input  logic [6:0]  h,
  output logic [17:0] colour
);

  logic [17:0] base_s;

  // Base colour per cell type.
  always_comb begin
    base_s = WALL_OTHER;
    case (col_type)
      3'd1:    base_s = WALL_T1;
      3'd2:    base_s = WALL_T2;
      3'd3:    base_s = WALL_T3;
      default: base_s = WALL_OTHER;
    endcase
  end

  // Distance shading.
  always_comb begin
    if (h < SHADE_LIMIT) begin
      colour = halve_channels(base_s);
    end else begin
      colour = base_s;
    end
  end

endmodule

// File: rtl/draw_fpv.sv
// FPV renderer: walks 160 columns, fetches each column's wall, paints 120 rows with back-pressure.
module draw_fpv
  import fpv_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  draw_fpv_if.slave  bus
);

  state_t      state_r;
  logic [7:0]  col_r;
  logic [6:0]  row_r;
  logic [6:0]  top_r;
  logic [6:0]  bottom_r;
  logic [17:0] wall_r;
  logic        done_r;
  logic [7:0]  col_addr_r;
  logic [7:0]  vga_x_r;
  logic [6:0]  vga_y_r;
  logic [17:0] vga_colour_r;
  logic        vga_write_r;

  logic [6:0]  h_s;
  logic [6:0]  top_s;
  logic [6:0]  bottom_s;
  logic [17:0] wall_s;
  logic [6:0]  row_next_s;

  // Clamp the fetched height and centre the wall span vertically.
  always_comb begin
    if (bus.col_height > MAX_H) begin
      h_s = MAX_H;
    end else begin
      h_s = bus.col_height;
    end
    top_s      = (MAX_H - h_s) >> 1'b1;
    bottom_s   = top_s + h_s;
    row_next_s = row_r + 7'd1;
  end

  fpv_wall_colour u_wall_colour (
    .col_type (bus.col_type),
    .h        (h_s),
    .colour   (wall_s)
  );

  // Render FSM with column/row counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      col_r        <= 8'd0;
      row_r        <= 7'd0;
      top_r        <= 7'd0;
      bottom_r     <= 7'd0;
      wall_r       <= 18'd0;
      done_r       <= 1'b0;
      col_addr_r   <= 8'd0;
      vga_x_r      <= 8'd0;
      vga_y_r      <= 7'd0;
      vga_colour_r <= 18'd0;
      vga_write_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r       <= 1'b0;
          col_addr_r   <= 8'd0;
          vga_x_r      <= 8'd0;
          vga_y_r      <= 7'd0;
          vga_colour_r <= 18'd0;
          vga_write_r  <= 1'b0;
          if (bus.start) begin
            state_r <= FETCH;
            col_r   <= 8'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH: begin
          state_r <= LATCH;
        end
        LATCH: begin
          top_r        <= top_s;
          bottom_r     <= bottom_s;
          wall_r       <= wall_s;
          row_r        <= 7'd0;
          vga_write_r  <= 1'b1;
          vga_x_r      <= col_r;
          vga_y_r      <= 7'd0;
          vga_colour_r <= pixel_colour(7'd0, top_s, bottom_s, wall_s);
          state_r      <= PAINT;
        end
        PAINT: begin
          // Everything holds while the sink refuses the pixel.
          if (bus.vga_ready) begin
            if (row_r == LAST_ROW) begin
              vga_write_r  <= 1'b0;
              vga_x_r      <= 8'd0;
              vga_y_r      <= 7'd0;
              vga_colour_r <= 18'd0;
              if (col_r == LAST_COL) begin
                done_r     <= 1'b1;
                col_addr_r <= 8'd0;
                state_r    <= DONE;
              end else begin
                col_r      <= col_r + 8'd1;
                col_addr_r <= col_r + 8'd1;
                state_r    <= FETCH;
              end
            end else begin
              row_r        <= row_next_s;
              vga_y_r      <= row_next_s;
              vga_colour_r <= pixel_colour(row_next_s, top_r, bottom_r, wall_r);
            end
          end else begin
            state_r <= PAINT;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          done_r       <= 1'b0;
          col_addr_r   <= 8'd0;
          vga_x_r      <= 8'd0;
          vga_y_r      <= 7'd0;
          vga_colour_r <= 18'd0;
          vga_write_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done       = done_r;
  assign bus.col_addr   = col_addr_r;
  assign bus.vga_x      = vga_x_r;
  assign bus.vga_y      = vga_y_r;
  assign bus.vga_colour = vga_colour_r;
  assign bus.vga_write  = vga_write_r;

endmodule
